// File: rtl/mux_tdm_n_pkg.sv
// Shared types and helpers for the TDM channel multiplexer family.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mux_mode_e;

  // Wide zero source; users take the low WIDTH bits.
  localparam logic [255:0] MUX_RST_DATA = '0;

  function automatic int unsigned selw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_tdm_n_if.sv
// Parallel-source / single-consumer bus of the TDM multiplexer.
interface mux_tdm_n_if
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SELW = selw(N_CH);

  logic [N_CH*WIDTH-1:0] i;
  logic [SELW-1:0]       sel;
  mux_mode_e             mode;
  logic                  en;
  logic [WIDTH-1:0]      y;
  logic [SELW-1:0]       y_ch;
  logic                  y_valid;
  logic                  frame_start;

  modport master (
    output i, sel, mode, en,
    input  y, y_ch, y_valid, frame_start
  );

  modport slave (
    input  i, sel, mode, en,
    output y, y_ch, y_valid, frame_start
  );
endinterface

// File: rtl/mux_tdm_n_scan_ctr.sv
// Scan position counter: channel index and dwell count with wrap.
module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned DWELL = 4,
  localparam int unsigned SELW = selw(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            adv,
  output logic [SELW-1:0] ch,
  output logic            last_dw,
  output logic            first
);
  localparam int unsigned DWW = selw(DWELL);

  logic [SELW-1:0] r_ch;
  logic [DWW-1:0]  r_dw;
  logic [DWW-1:0]  w_dw;
  logic [SELW-1:0] w_ch_nxt;
  logic [DWW-1:0]  w_dw_nxt;

  // clr takes effect in the same cycle, so the switching cycle already scans channel 0
  assign ch      = clr ? '0 : r_ch;
  assign w_dw    = clr ? '0 : r_dw;
  assign last_dw = (w_dw == DWW'(DWELL - 1));
  assign first   = (ch == '0) && (w_dw == '0);

  always_comb begin
    w_ch_nxt = ch;
    w_dw_nxt = w_dw;
    if (adv) begin
      if (last_dw) begin
        w_dw_nxt = '0;
        w_ch_nxt = (ch == SELW'(N_CH - 1)) ? '0 : ch + SELW'(1);
      end else begin
        w_dw_nxt = w_dw + DWW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch <= '0;
      r_dw <= '0;
    end else begin
      r_ch <= w_ch_nxt;
      r_dw <= w_dw_nxt;
    end
  end
endmodule

// File: rtl/mux_tdm_n.sv
// Registered N:1 multiplexer with manual select and auto-scan modes.
module mux_tdm_n
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_tdm_n_if.slave bus
);
  localparam int unsigned SELW = selw(N_CH);

  mux_mode_e        r_mode;
  mux_mode_e        w_mode_nxt;
  logic             w_clr;
  logic             w_adv;
  logic [SELW-1:0]  w_ch;
  logic             w_last_dw;
  logic             w_first;
  logic             w_sel_ok;
  logic [WIDTH-1:0] w_data [N_CH];

  logic [WIDTH-1:0] r_y;
  logic [SELW-1:0]  r_y_ch;
  logic             r_valid;
  logic             r_fs;

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_data[k] = bus.i[k*WIDTH +: WIDTH];
    end
  end

  assign w_sel_ok = (32'(bus.sel) < N_CH);

  always_ff @(posedge clk) begin
    if (!rst_n) r_mode <= MODE_MANUAL;
    else        r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = bus.mode;
    w_clr      = 1'b0;
    w_adv      = 1'b0;
    if (bus.mode == MODE_SCAN) begin
      w_clr = (r_mode == MODE_MANUAL);
      w_adv = bus.en;
    end
  end

  mux_scan_ctr #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .adv     (w_adv),
    .ch      (w_ch),
    .last_dw (w_last_dw),
    .first   (w_first)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y     <= MUX_RST_DATA[WIDTH-1:0];
      r_y_ch  <= '0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
    end else if (!bus.en) begin
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
    end else if (bus.mode == MODE_SCAN) begin
      r_y     <= w_data[w_ch];
      r_y_ch  <= w_ch;
      r_valid <= 1'b1;
      r_fs    <= w_first;
    end else begin
      r_y     <= w_sel_ok ? w_data[bus.sel] : MUX_RST_DATA[WIDTH-1:0];
      r_y_ch  <= bus.sel;
      r_valid <= w_sel_ok;
      r_fs    <= 1'b0;
    end
  end

  assign bus.y           = r_y;
  assign bus.y_ch        = r_y_ch;
  assign bus.y_valid     = r_valid;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_mux_tdm_n.sv
// Scoreboard bench for mux_tdm_n: N_CH=8/DWELL=4 and N_CH=5/DWELL=1 instances.
module tb_mux_tdm_n;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  mux_tdm_n_if #(.N_CH(8), .WIDTH(8)) ifa ();
  mux_tdm_n_if #(.N_CH(5), .WIDTH(8)) ifb ();

  mux_tdm_n #(.N_CH(8), .WIDTH(8), .DWELL(4)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
  mux_tdm_n #(.N_CH(5), .WIDTH(8), .DWELL(1)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

  typedef struct {
    bit         b;
    logic [7:0] y;
    logic [2:0] ch;
    logic       v;
    logic       fs;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick(input bit b, input logic [7:0] y, input logic [2:0] ch,
                      input logic v, input logic fs, input string nm);
    exp_t e;
    @(posedge clk);
    e.b = b; e.y = y; e.ch = ch; e.v = v; e.fs = fs; e.nm = nm;
    q.push_back(e);
    #1;
  endtask

  task automatic scan_a(input int n0, input int cnt, input string nm);
    logic [2:0] c;
    for (int n = n0; n < n0 + cnt; n++) begin
      c = 3'(((n - 1) / 4) % 8);
      tick(1'b0, 8'h10 + 8'(c), c, 1'b1, ((n - 1) % 32) == 0, nm);
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] ay;
    logic [2:0] ach;
    logic       av;
    logic       afs;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.b) begin
        ay = ifb.y; ach = ifb.y_ch; av = ifb.y_valid; afs = ifb.frame_start;
      end else begin
        ay = ifa.y; ach = ifa.y_ch; av = ifa.y_valid; afs = ifa.frame_start;
      end
      n_cmp++;
      if (ay !== e.y || ach !== e.ch || av !== e.v || afs !== e.fs) begin
        n_bad++;
        $display("FAIL %s: got y=%h ch=%0d v=%b fs=%b, want y=%h ch=%0d v=%b fs=%b",
                 e.nm, ay, ach, av, afs, e.y, e.ch, e.v, e.fs);
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) ifa.i[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 5; k++) ifb.i[k*8 +: 8] = 8'h20 + 8'(k);
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.mode = MODE_SCAN;   ifa.en = 1'b1; ifa.sel = 3'd0;
    ifb.mode = MODE_MANUAL; ifb.en = 1'b1; ifb.sel = 3'd7;

    tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "rst_a");
    rst_a = 1'b1;
    scan_a(1, 40, "scan");
    scan_a(41, 14, "scan_cont");

    rst_a = 1'b0;
    tick(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "rst_mid");
    rst_a = 1'b1;
    scan_a(1, 10, "post_rst");

    ifa.en = 1'b0;
    repeat (3) tick(1'b0, 8'h12, 3'd2, 1'b0, 1'b0, "freeze");
    ifa.en = 1'b1;
    scan_a(11, 15, "resume");

    ifa.mode = MODE_MANUAL; ifa.sel = 3'd1;
    repeat (2) tick(1'b0, 8'h11, 3'd1, 1'b1, 1'b0, "man_sel1");
    ifa.mode = MODE_SCAN;
    scan_a(1, 5, "rescan");

    ifa.mode = MODE_MANUAL;
    ifa.sel = 3'd3; tick(1'b0, 8'h13, 3'd3, 1'b1, 1'b0, "man3");
    ifa.sel = 3'd6; tick(1'b0, 8'h16, 3'd6, 1'b1, 1'b0, "man6");
    ifa.sel = 3'd0; tick(1'b0, 8'h10, 3'd0, 1'b1, 1'b0, "man0");
    ifa.en = 1'b0; ifa.sel = 3'd5;
    tick(1'b0, 8'h10, 3'd0, 1'b0, 1'b0, "man_freeze");
    ifa.en = 1'b1;

    rst_b = 1'b1;
    tick(1'b1, 8'h00, 3'd7, 1'b0, 1'b0, "oor_sel7");
    ifb.sel = 3'd4;
    tick(1'b1, 8'h24, 3'd4, 1'b1, 1'b0, "b_sel4");
    ifb.mode = MODE_SCAN;
    for (int k = 0; k < 7; k++) begin
      logic [2:0] c;
      c = 3'(k % 5);
      tick(1'b1, 8'h20 + 8'(c), c, 1'b1, c == 3'd0, "b_scan_d1");
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
